// File: rtl/rc4_pkg.sv
// Shared types for the RC4 key-scheduling datapath.
package rc4_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        IDLE,
        RD_SI,
        WAIT_SI,
        LATCH_SI,
        RD_SJ,
        WAIT_SJ,
        LATCH_SJ,
        WR_SI,
        WR_SJ,
        INC,
        DONE
    } ksa_state_t;

    localparam int S_SIZE = 256;

endpackage

// File: rtl/rc4_key_byte_sel.sv
// Key byte selector: mod-KEY_BYTES index counter and key byte mux.
// Byte 0 is the most-significant byte of key.
module rc4_key_byte_sel
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   advance,
    input  logic [8*KEY_BYTES-1:0] key,
    output byte_t                  keybyte
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0] LAST = KW'(KEY_BYTES - 1);

    logic [KW-1:0] r_kidx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kidx <= '0;
        end else if (clear) begin
            r_kidx <= '0;
        end else if (advance) begin
            r_kidx <= (r_kidx == LAST) ? '0 : r_kidx + 1'b1;
        end
    end

    assign keybyte = key[8*(KEY_BYTES-1-int'(r_kidx)) +: 8];

endmodule

// File: rtl/rc4_ksa_swap.sv
// RC4 KSA swap stage: permutes the identity-filled S-RAM using the key.
// Define RC4_KSA_SKIP_SELF_SWAP_EN to skip the sj read/writes when j == i.
module rc4_ksa_swap
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [7:0]             mem_rddata,
    output logic [7:0]             mem_address,
    output logic [7:0]             mem_wrdata,
    output logic                   mem_wren,
    output logic                   selector,
    output logic                   finish
);

    localparam byte_t LAST_I = byte_t'(S_SIZE - 1);

    ksa_state_t r_state;
    ksa_state_t w_next;
    byte_t      r_i;
    byte_t      r_j;
    byte_t      r_si;
    byte_t      r_sj;
    byte_t      w_keybyte;
    byte_t      w_jn;
    logic       w_clear;
    logic       w_adv;

    rc4_key_byte_sel #(
        .KEY_BYTES(KEY_BYTES)
    ) u_ksel (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .advance(w_adv),
        .key    (key),
        .keybyte(w_keybyte)
    );

    assign w_jn = r_j + mem_rddata + w_keybyte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        mem_address = '0;
        mem_wrdata  = '0;
        mem_wren    = 1'b0;
        selector    = 1'b1;
        finish      = 1'b0;
        w_clear     = 1'b0;
        w_adv       = 1'b0;
        unique case (r_state)
            IDLE: begin
                selector = 1'b0;
                if (start) begin
                    w_clear = 1'b1;
                    w_next  = RD_SI;
                end
            end
            RD_SI: begin
                mem_address = r_i;
                w_next      = WAIT_SI;
            end
            WAIT_SI: begin
                mem_address = r_i;
                w_next      = LATCH_SI;
            end
            LATCH_SI: begin
                mem_address = r_i;
                w_next      = RD_SJ;
`ifdef RC4_KSA_SKIP_SELF_SWAP_EN
                if (w_jn == r_i) w_next = INC;
`endif
            end
            RD_SJ: begin
                mem_address = r_j;
                w_next      = WAIT_SJ;
            end
            WAIT_SJ: begin
                mem_address = r_j;
                w_next      = LATCH_SJ;
            end
            LATCH_SJ: begin
                mem_address = r_j;
                w_next      = WR_SI;
            end
            WR_SI: begin
                mem_address = r_i;
                mem_wrdata  = r_sj;
                mem_wren    = 1'b1;
                w_next      = WR_SJ;
            end
            WR_SJ: begin
                mem_address = r_j;
                mem_wrdata  = r_si;
                mem_wren    = 1'b1;
                w_next      = INC;
            end
            INC: begin
                if (r_i == LAST_I) begin
                    w_next = DONE;
                end else begin
                    w_adv  = 1'b1;
                    w_next = RD_SI;
                end
            end
            DONE: begin
                finish = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_i  <= '0;
            r_j  <= '0;
            r_si <= '0;
            r_sj <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_i <= '0;
                        r_j <= '0;
                    end
                end
                LATCH_SI: begin
                    r_si <= mem_rddata;
                    r_j  <= w_jn;
                end
                LATCH_SJ: r_sj <= mem_rddata;
                INC: begin
                    if (r_i != LAST_I) r_i <= r_i + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_ksa_swap.sv
// Self-checking bench for rc4_ksa_swap against a plain-loop RC4 KSA model.
// The bench owns the S-RAM (synchronous read, registered write).
module tb_rc4_ksa_swap;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] key;
    logic [7:0]  mem_rddata;
    logic [7:0]  mem_address;
    logic [7:0]  mem_wrdata;
    logic        mem_wren;
    logic        selector;
    logic        finish;

    logic [7:0]  ram [256];
    logic [7:0]  gold [256];
    logic        init_req = 1'b0;
    logic        cap = 1'b0;
    logic [15:0] wq [$];

    int total = 0;
    int bad = 0;

    rc4_ksa_swap #(.KEY_BYTES(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key        (key),
        .mem_rddata (mem_rddata),
        .mem_address(mem_address),
        .mem_wrdata (mem_wrdata),
        .mem_wren   (mem_wren),
        .selector   (selector),
        .finish     (finish)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < 256; k++) ram[k] <= 8'(k);
        end else if (mem_wren) begin
            ram[mem_address] <= mem_wrdata;
        end
        mem_rddata <= ram[mem_address];
        if (mem_wren && cap) wq.push_back({mem_address, mem_wrdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Textbook KSA; returns the expected cycle count to the finish pulse.
    function automatic int ksa_model(input logic [23:0] k);
        int j;
        int cyc;
        int kb;
        logic [7:0] t;
        for (int n = 0; n < 256; n++) gold[n] = 8'(n);
        j = 0;
        cyc = 0;
        for (int n = 0; n < 256; n++) begin
            kb = int'((k >> (8 * (2 - (n % 3)))) & 24'hFF);
            j = (j + int'(gold[n]) + kb) % 256;
`ifdef RC4_KSA_SKIP_SELF_SWAP_EN
            cyc += (j == n) ? 4 : 9;
`else
            cyc += 9;
`endif
            t = gold[n];
            gold[n] = gold[j];
            gold[j] = t;
        end
        return cyc;
    endfunction

    task automatic init_ram();
        @(negedge clk) init_req = 1'b1;
        @(negedge clk) init_req = 1'b0;
    endtask

    task automatic run(input logic [23:0] k, input int pulse_at,
                       input int rst_at, output int cyc);
        cyc = -1;
        key = k;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 3000; n++) begin
            if (n == pulse_at) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            if (n == rst_at) begin
                #2 reset = 1'b0;
                #1;
                chk("abort_outs",
                    {19'd0, selector, finish, mem_wren, mem_address, mem_wrdata}, 0);
                cyc = n;
                return;
            end
            if (finish) begin
                cyc = n;
                break;
            end
        end
        @(posedge clk);
        #1;
        chk("fin_one_cycle", finish, 0);
        chk("sel_falls", selector, 0);
    endtask

    task automatic cmp_array(input string tag);
        int mism = 0;
        for (int n = 0; n < 256; n++) if (ram[n] !== gold[n]) mism++;
        chk(tag, mism, 0);
    endtask

    initial begin
        int cyc;
        int exp_cyc;
        logic [23:0] kr;

        reset = 1'b0;
        start = 1'b0;
        key   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_selector", selector, 0);
        chk("rst_finish", finish, 0);
        chk("rst_wren", mem_wren, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_wrdata", mem_wrdata, 0);
        @(negedge clk) reset = 1'b1;

        init_ram();
        exp_cyc = ksa_model(24'h000000);
        run(24'h000000, 0, 0, cyc);
        chk("key0_latency", cyc, exp_cyc);
        cmp_array("key0_array");

        init_ram();
        exp_cyc = ksa_model(24'h010203);
        wq.delete();
        cap = 1'b1;
        run(24'h010203, 0, 0, cyc);
        cap = 1'b0;
        chk("k123_latency", cyc, exp_cyc);
        chk("k123_wr0", wq.size() > 0 ? wq[0] : 16'hFFFF, 16'h0001);
        chk("k123_wr1", wq.size() > 1 ? wq[1] : 16'hFFFF, 16'h0100);
        cmp_array("k123_array");

        for (int r = 0; r < 20; r++) begin
            kr = 24'($urandom);
            init_ram();
            exp_cyc = ksa_model(kr);
            run(kr, 0, 0, cyc);
            chk("rand_latency", cyc, exp_cyc);
            cmp_array("rand_array");
        end

        init_ram();
        kr = 24'($urandom);
        exp_cyc = ksa_model(kr);
        run(kr, 500, 0, cyc);
        chk("midstart_latency", cyc, exp_cyc);
        cmp_array("midstart_array");

        init_ram();
        run(24'h5a3c77, 0, 1000, cyc);
        chk("abort_at", cyc, 1000);
        @(posedge clk);
        #1;
        chk("abort_hold_sel", selector, 0);
        @(negedge clk) reset = 1'b1;

        init_ram();
        kr = 24'($urandom);
        exp_cyc = ksa_model(kr);
        run(kr, 0, 0, cyc);
        chk("recover_latency", cyc, exp_cyc);
        cmp_array("recover_array");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rc4_ksa_swap.md
Name: rc4_ksa_swap

Overview:
RC4 key-scheduling stage that runs after the S-array identity fill (s[i]=i) has completed. It owns the single-port 256x8 S-array RAM while busy. For i = 0..255 it computes j = j + s[i] + key[i mod KEY_BYTES] and swaps s[i] with s[j]. It pulses finish for the downstream PRGA/decrypt stage.

Parameters:
KEY_BYTES, 3, number of secret-key bytes; key byte index = i mod KEY_BYTES.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
start  input  1  level; sampled only in IDLE
key  input  8*KEY_BYTES  secret key; byte 0 = most-significant byte (key[8*KEY_BYTES-1 -: 8])
mem_rddata  input  8  S-RAM read data
mem_address  output  8  S-RAM address
mem_wrdata  output  8  S-RAM write data
mem_wren  output  1  S-RAM write enable
selector  output  1  high = this block drives the RAM mux
finish  output  1  one-cycle done pulse

Behaviour:
- Reset (async, active-low): state=IDLE; i=0, j=0, kidx=0, si=0, sj=0. All outputs are 0.
- RAM model: synchronous read. An address presented in cycle N is sampled into a register in cycle N+2 (one WAIT state).
- FSM per iteration, 9 cycles:
  - RD_SI: addr=i.
  - WAIT_SI: addr=i.
  - LATCH_SI: si<=rddata; j<=j+rddata+keybyte[kidx], mod 256.
  - RD_SJ: addr=j.
  - WAIT_SJ: addr=j.
  - LATCH_SJ: sj<=rddata.
  - WR_SI: addr=i, wrdata=sj, wren=1.
  - WR_SJ: addr=j, wrdata=si, wren=1.
  - INC: if i==255 go to DONE; else i++, kidx = (kidx==KEY_BYTES-1) ? 0 : kidx+1, go to RD_SI.
- IDLE: if start, clear i, j and kidx, then go to RD_SI. DONE: finish=1 for one cycle, then go to IDLE.
- Latency: RD_SI is entered at the edge that samples start (edge 0). DONE is entered at edge 2304 (256x9).
- selector=1 in every state except IDLE.
- mem_wren=1 only in WR_SI and WR_SJ. mem_address=0 in IDLE and DONE.
- Arithmetic: all 8-bit with wrap; no carry is kept. i wraps implicitly but terminates at 255.
- i==j: reads return the same value and both writes write it back. The S-array is unchanged; this is correct and requires no special case.
- start asserted while busy is ignored. start still high on return to IDLE starts a new run with no check. Upstream must re-initialise first.
- key must be stable from start to finish. The block does not register key.
- Reset mid-run aborts immediately. The RAM contents are left partially permuted.

Optional Feature:
- Macro: RC4_KSA_SKIP_SELF_SWAP_EN.
- Enabled: in LATCH_SI, if the new j equals i, the FSM goes directly to INC. No sj read and no writes occur, and that iteration takes 4 cycles.
- Disabled: every iteration takes 9 cycles, as above.
- Final RAM contents are identical in both modes.

Decomposition:
- Package rc4_pkg: byte_t (logic [7:0]); ksa_state_t enum (IDLE, RD_SI, WAIT_SI, LATCH_SI, RD_SJ, WAIT_SJ, LATCH_SJ, WR_SI, WR_SJ, INC, DONE); localparam S_SIZE=256.
- Sub-module rc4_key_byte_sel: mod-KEY_BYTES index counter plus key byte mux. Inputs: clear, advance. Output: keybyte.

Test Plan:
- Identity RAM, key=24'h000000: after run, s[0]=0, s[1]=1, s[2]=3, s[3]=2 (i=2 gives j=3). finish rises exactly 2304 cycles after the start-sampling edge.
- Identity RAM, key=24'h010203: at i=0, j=1, so the write sequence is (addr 0, data 1) then (addr 1, data 0). Full final array matches a C/SV golden KSA model.
- Random 24-bit key, 20 runs: final 256-byte array equals the golden model; finish is high for exactly one cycle and selector falls the cycle after.
- start pulsed at cycle 500 mid-run: no restart, completion time unchanged. Reset asserted at cycle 1000: outputs 0 and state IDLE immediately, asynchronously.
- With RC4_KSA_SKIP_SELF_SWAP_EN and key=24'h000000: iteration i=0 makes no writes and takes 4 cycles. Final array is identical to the macro-off run.
